// File: rtl/wait_arb_pkg.sv
// rtl/wait_arb_pkg.sv - shared types and constants for the wait arbiter
//
// Contents:
//   wait_arb_state_t        arbiter FSM state encoding
//   WAIT_ARB_MAX_CLIENTS    largest supported client count
//   WAIT_ARB_DEFAULT_WIDTH  default delay value width
package wait_arb_pkg;

    localparam int WAIT_ARB_MAX_CLIENTS   = 16;
    localparam int WAIT_ARB_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } wait_arb_state_t;

endpackage

// File: rtl/wait_arb_pick.sv
// rtl/wait_arb_pick.sv - combinational winner selection for the wait arbiter
//
// Macro WAIT_ARB_FIXED_PRIO_EN: when defined, the lowest-index valid client
// wins and last_grant is ignored; otherwise round-robin starting one past
// last_grant.
//
// Ports:
//   req_valid   in   per-client request vector
//   last_grant  in   index of the most recent grant (round-robin origin)
//   any         out  at least one request is valid
//   winner      out  index of the selected client (0 when none valid)
module wait_arb_pick
    import wait_arb_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int IDX_W     = $clog2(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req_valid,
    input  logic [IDX_W-1:0]     last_grant,
    output logic                 any,
    output logic [IDX_W-1:0]     winner
);

    assign any = |req_valid;

`ifdef WAIT_ARB_FIXED_PRIO_EN

    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Scan from the top down so the lowest valid index is the last write.
    always_comb begin
        winner = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

`else

    logic             found;
    logic [IDX_W-1:0] idx;

    // Visit clients in the order last_grant+1, last_grant+2, ... wrapping
    // modulo N_CLIENTS; last_grant itself is visited last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % N_CLIENTS);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

`endif

endmodule

// File: rtl/wait_arbiter.sv
// rtl/wait_arbiter.sv - shares one wait_cycles engine among N client threads
//
// Macro WAIT_ARB_FIXED_PRIO_EN: selects fixed-priority arbitration instead of
// round-robin (see wait_arb_pick); FSM and timing are the same in both modes.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req_valid  in   [N_CLIENTS]        per-client request, held until req_ready
//   req_0      in   [N_CLIENTS*WIDTH]  per-client delay, slice i = [i*WIDTH +: WIDTH]
//   req_ready  out  [N_CLIENTS]        one-cycle completion pulse to the owner
//   out_valid  out                     one-cycle request pulse to the wait unit
//   out_0      out  [WIDTH]            delay of the granted request
//   out_ready  in                      completion pulse from the wait unit
module wait_arbiter
    import wait_arb_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int WIDTH     = WAIT_ARB_DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CLIENTS-1:0]       req_valid,
    input  logic [N_CLIENTS*WIDTH-1:0] req_0,
    output logic [N_CLIENTS-1:0]       req_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_0,
    input  logic                       out_ready
);

    localparam int IDX_W = $clog2(N_CLIENTS);

    wait_arb_state_t        state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [WIDTH-1:0]       out_0_q;
    logic                   out_valid_q;
    logic [N_CLIENTS-1:0]   req_ready_q;

    logic                   pick_any;
    logic [IDX_W-1:0]       pick_winner;
    logic [IDX_W-1:0]       pick_last;

`ifdef WAIT_ARB_FIXED_PRIO_EN
    assign pick_last = '0;
`else
    // Reset origin is the top index so client 0 is searched first.
    localparam logic [IDX_W-1:0] LAST_GRANT_RESET = IDX_W'(N_CLIENTS - 1);

    logic [IDX_W-1:0]       last_grant_q;
    assign pick_last = last_grant_q;
`endif

    wait_arb_pick #(
        .N_CLIENTS (N_CLIENTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (pick_last),
        .any        (pick_any),
        .winner     (pick_winner)
    );

    // req_valid is only looked at in IDLE and out_ready only in WAIT, so a
    // client dropping its request mid-flight or a stray completion cannot
    // disturb the request in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            out_0_q      <= '0;
            out_valid_q  <= 1'b0;
            req_ready_q  <= '0;
`ifndef WAIT_ARB_FIXED_PRIO_EN
            last_grant_q <= LAST_GRANT_RESET;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q      <= pick_winner;
                        out_0_q      <= req_0[pick_winner*WIDTH +: WIDTH];
                        out_valid_q  <= 1'b1;
`ifndef WAIT_ARB_FIXED_PRIO_EN
                        last_grant_q <= pick_winner;
`endif
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    out_valid_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (out_ready) begin
                        req_ready_q[grant_q] <= 1'b1;
                        state_q              <= DONE;
                    end
                end
                DONE: begin
                    // Extra cycle lets the owner drop req_valid before the
                    // next IDLE so it is not granted a second time.
                    req_ready_q <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_0     = out_0_q;

endmodule

// File: tb/tb_wait_arbiter.sv
// tb/tb_wait_arbiter.sv - self-checking bench for wait_arbiter
module tb_wait_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_0;
    logic           out_ready;

    always #5 clk = ~clk;

    wait_arbiter #(.N_CLIENTS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_0     (req_0),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_0     (out_0),
        .out_ready (out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // client model: valid/delay per client, plus extra back-to-back requests
    logic [N-1:0] cli_valid;
    logic [W-1:0] cli_delay [N];
    int           remaining [N];
    logic [N-1:0] drv_valid_prev;
    logic [W-1:0] drv_delay_prev [N];

    // reference arbiter + downstream wait unit
    int   m_last;
    logic inflight, ds_busy, ov_last, inject;
    int   ds_cnt;
    int   exp_rdy_cyc;
    int   err_pulse, err_onehot, err_overlap, err_timing, err_nogrant;

    int           exp_client [$];
    logic [W-1:0] exp_val [$];
    logic [W-1:0] obs_ov_val [$];
    int           obs_ov_cyc [$];
    int           obs_rdy_client [$];
    int           obs_rdy_cyc [$];

    function automatic int model_pick(input logic [N-1:0] v, input int last);
`ifdef WAIT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic int err_sum();
        return err_pulse + err_onehot + err_overlap + err_timing + err_nogrant;
    endfunction

    task automatic clear_logs();
        exp_client.delete(); exp_val.delete();
        obs_ov_val.delete(); obs_ov_cyc.delete();
        obs_rdy_client.delete(); obs_rdy_cyc.delete();
        err_pulse = 0; err_onehot = 0; err_overlap = 0; err_timing = 0; err_nogrant = 0;
    endtask

    task automatic drive_inputs();
        req_valid = cli_valid;
        for (int i = 0; i < N; i++) req_0[i*W +: W] = cli_delay[i];
        drv_valid_prev = cli_valid;
        drv_delay_prev = cli_delay;
    endtask

    // One cycle: sample outputs at negedge, update models, drive inputs.
    task automatic step();
        int   w;
        logic fire, loaded;
        @(negedge clk);
        cyc++;
        fire = 1'b0;
        loaded = 1'b0;
        if (!rst) begin
            if (out_valid === 1'b1) begin
                if (ov_last) err_pulse++;
                if (inflight) err_overlap++;
                w = model_pick(drv_valid_prev, m_last);
                if (w < 0) err_nogrant++;
                else begin
                    exp_client.push_back(w);
                    exp_val.push_back(drv_delay_prev[w]);
                    m_last = w;
                end
                obs_ov_val.push_back(out_0);
                obs_ov_cyc.push_back(cyc);
                inflight = 1'b1;
                ds_busy  = 1'b1;
                ds_cnt   = (out_0 > 32'd64) ? 64 : int'(out_0);
                loaded   = 1'b1;
            end
            ov_last = (out_valid === 1'b1);
            if (req_ready !== '0) begin
                if ($countones(req_ready) != 1) err_onehot++;
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i] === 1'b1) begin
                        obs_rdy_client.push_back(i);
                        if (remaining[i] > 0) begin
                            remaining[i]--;
                            cli_delay[i] = $urandom_range(0, 7);
                        end else begin
                            cli_valid[i] = 1'b0;
                        end
                    end
                end
                obs_rdy_cyc.push_back(cyc);
                inflight = 1'b0;
            end
            if (exp_rdy_cyc == cyc) begin
                if (req_ready === '0) err_timing++;
                exp_rdy_cyc = -1;
            end else if (req_ready !== '0) begin
                err_timing++;
            end
            if (ds_busy && !loaded) begin
                if (ds_cnt == 0) begin
                    fire        = 1'b1;
                    ds_busy     = 1'b0;
                    exp_rdy_cyc = cyc + 1;
                end else begin
                    ds_cnt--;
                end
            end
        end
        out_ready = fire | inject;
        inject    = 1'b0;
        drive_inputs();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        cli_valid = '0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            cli_delay[i] = '0;
        end
        inject = 1'b0; ds_busy = 1'b0; inflight = 1'b0; ov_last = 1'b0;
        exp_rdy_cyc = -1; m_last = N - 1; out_ready = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        assert_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (cli_valid == '0 && !inflight && exp_rdy_cyc < 0 && !ds_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        clear_logs();
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_0 !== '0) begin n_fail++; $display("FAIL reset_out_0: got %0d expected 0", out_0); end
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (obs_ov_val.size() != 0 || err_sum() != 0) begin n_fail++; $display("FAIL reset_idle_quiet: got %0d grants %0d errors expected 0 0", obs_ov_val.size(), err_sum()); end
    endtask

    task automatic test_single();
        bit ok;
        int c0;
        do_reset();
        clear_logs();
        cli_delay[1] = 5;
        cli_valid[1] = 1'b1;
        step();
        c0 = cyc;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got busy expected idle"); end
        n_checks++; if (obs_ov_cyc.size() != 1 || obs_ov_cyc[0] != c0 + 1) begin n_fail++; $display("FAIL single_issue_cycle: got %0d pulses expected 1 at %0d", obs_ov_cyc.size(), c0 + 1); end
        n_checks++; if ((obs_ov_val.size() == 1 ? obs_ov_val[0] : 32'hffff_ffff) !== 32'd5) begin n_fail++; $display("FAIL single_out_0: got %0d expected 5", obs_ov_val.size() == 1 ? obs_ov_val[0] : 32'hffff_ffff); end
        n_checks++; if (obs_rdy_client.size() != 1 || obs_rdy_client[0] != 1) begin n_fail++; $display("FAIL single_ready_client: got %0d pulses expected one on client 1", obs_rdy_client.size()); end
        n_checks++; if (obs_rdy_cyc.size() != 1 || obs_rdy_cyc[0] != c0 + 8) begin n_fail++; $display("FAIL single_ready_cycle: got %0d expected %0d", obs_rdy_cyc.size() == 1 ? obs_rdy_cyc[0] : -1, c0 + 8); end
        n_checks++; if (err_sum() != 0) begin n_fail++; $display("FAIL single_protocol: got %0d errors expected 0", err_sum()); end
        step();
        step();
        n_checks++; if (out_0 !== 32'd5) begin n_fail++; $display("FAIL single_out_0_hold: got %0d expected 5", out_0); end
    endtask

    task automatic test_all_four();
        bit ok;
        int exp_order [4] = '{0, 1, 2, 3};
        logic [W-1:0] exp_d [4] = '{32'd3, 32'd0, 32'd7, 32'd1};
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) begin
            cli_delay[i] = exp_d[i];
            cli_valid[i] = 1'b1;
        end
        step();
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL all4_timeout: got busy expected idle"); end
        n_checks++; if (obs_rdy_client.size() != 4) begin n_fail++; $display("FAIL all4_count: got %0d expected 4", obs_rdy_client.size()); end
        for (int i = 0; i < 4 && i < obs_rdy_client.size(); i++) begin
            n_checks++; if (obs_rdy_client[i] != exp_order[i]) begin n_fail++; $display("FAIL all4_order[%0d]: got %0d expected %0d", i, obs_rdy_client[i], exp_order[i]); end
            n_checks++; if (obs_ov_val[i] !== exp_d[exp_order[i]]) begin n_fail++; $display("FAIL all4_out_0[%0d]: got %0d expected %0d", i, obs_ov_val[i], exp_d[exp_order[i]]); end
        end
        for (int i = 0; i + 1 < obs_ov_cyc.size() && i < obs_rdy_cyc.size(); i++) begin
            n_checks++; if (obs_ov_cyc[i+1] != obs_rdy_cyc[i] + 2) begin n_fail++; $display("FAIL all4_turnaround[%0d]: got %0d expected %0d", i, obs_ov_cyc[i+1], obs_rdy_cyc[i] + 2); end
        end
        n_checks++; if (err_sum() != 0) begin n_fail++; $display("FAIL all4_protocol: got %0d errors expected 0", err_sum()); end
    endtask

    task automatic test_fairness();
        bit ok;
`ifdef WAIT_ARB_FIXED_PRIO_EN
        int exp_order [8] = '{0, 0, 0, 0, 2, 2, 2, 2};
`else
        int exp_order [8] = '{0, 2, 0, 2, 0, 2, 0, 2};
`endif
        do_reset();
        clear_logs();
        cli_valid[0] = 1'b1; cli_delay[0] = $urandom_range(0, 7); remaining[0] = 3;
        cli_valid[2] = 1'b1; cli_delay[2] = $urandom_range(0, 7); remaining[2] = 3;
        step();
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fair_timeout: got busy expected idle"); end
        n_checks++; if (obs_rdy_client.size() != 8) begin n_fail++; $display("FAIL fair_count: got %0d expected 8", obs_rdy_client.size()); end
        for (int i = 0; i < 8 && i < obs_rdy_client.size(); i++) begin
            n_checks++; if (obs_rdy_client[i] != exp_order[i]) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, obs_rdy_client[i], exp_order[i]); end
        end
        for (int i = 0; i < obs_ov_val.size() && i < exp_val.size(); i++) begin
            n_checks++; if (obs_ov_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL fair_out_0[%0d]: got %0d expected %0d", i, obs_ov_val[i], exp_val[i]); end
        end
        n_checks++; if (err_sum() != 0) begin n_fail++; $display("FAIL fair_protocol: got %0d errors expected 0", err_sum()); end
    endtask

    task automatic test_spurious();
        bit ok;
        int c0;
        int d;
        do_reset();
        clear_logs();
        inject = 1'b1; step();
        inject = 1'b1; step();
        step();
        n_checks++; if (obs_rdy_client.size() != 0 || obs_ov_cyc.size() != 0) begin n_fail++; $display("FAIL spur_idle: got %0d ready %0d issue expected 0 0", obs_rdy_client.size(), obs_ov_cyc.size()); end
        d = $urandom_range(0, 7);
        cli_delay[2] = d;
        cli_valid[2] = 1'b1;
        step();
        c0 = cyc;
        inject = 1'b1;
        step();
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL spur_timeout: got busy expected idle"); end
        n_checks++; if (obs_ov_cyc.size() != 1 || obs_ov_cyc[0] != c0 + 1) begin n_fail++; $display("FAIL spur_issue_cycle: got %0d pulses expected 1 at %0d", obs_ov_cyc.size(), c0 + 1); end
        n_checks++; if (obs_rdy_client.size() != 1 || obs_rdy_client[0] != 2) begin n_fail++; $display("FAIL spur_ready_client: got %0d pulses expected one on client 2", obs_rdy_client.size()); end
        n_checks++; if (obs_rdy_cyc.size() != 1 || obs_rdy_cyc[0] != c0 + 3 + d) begin n_fail++; $display("FAIL spur_ready_cycle: got %0d expected %0d", obs_rdy_cyc.size() == 1 ? obs_rdy_cyc[0] : -1, c0 + 3 + d); end
        n_checks++; if (err_sum() != 0) begin n_fail++; $display("FAIL spur_protocol: got %0d errors expected 0", err_sum()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        clear_logs();
        cli_delay[0] = 20;
        cli_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        assert_reset();
        step();
        n_checks++; if (req_ready !== '0 || out_valid !== 1'b0 || out_0 !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got rdy=%b ov=%b out_0=%0d expected 0 0 0", req_ready, out_valid, out_0); end
        n_checks++; if (obs_rdy_client.size() != 0) begin n_fail++; $display("FAIL rstmid_abandon: got %0d ready pulses expected 0", obs_rdy_client.size()); end
        rst = 1'b0;
        clear_logs();
        cli_valid[3] = 1'b1; cli_delay[3] = $urandom_range(0, 7);
        cli_valid[0] = 1'b1; cli_delay[0] = $urandom_range(0, 7);
        step();
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got busy expected idle"); end
        n_checks++; if (obs_rdy_client.size() != 2 || obs_rdy_client[0] != 0 || obs_rdy_client[1] != 3) begin n_fail++; $display("FAIL rstmid_order: got %0d grants first %0d expected 2 grants 0 then 3", obs_rdy_client.size(), obs_rdy_client.size() > 0 ? obs_rdy_client[0] : -1); end
        n_checks++; if (err_sum() != 0) begin n_fail++; $display("FAIL rstmid_protocol: got %0d errors expected 0", err_sum()); end
    endtask

    task automatic test_withdraw_zero();
        bit ok;
        int c1;
        do_reset();
        clear_logs();
        cli_delay[0] = 6;
        cli_valid[0] = 1'b1;
        step();
        step();
        cli_delay[2] = 3;
        cli_valid[2] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        cli_valid[2] = 1'b0;
        wait_idle(ok);
        cli_delay[1] = 0;
        cli_valid[1] = 1'b1;
        step();
        c1 = cyc;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wd_timeout: got busy expected idle"); end
        n_checks++; if (obs_rdy_client.size() != 2 || obs_rdy_client[0] != 0 || obs_rdy_client[1] != 1) begin n_fail++; $display("FAIL wd_clients: got %0d grants expected clients 0 then 1", obs_rdy_client.size()); end
        n_checks++; if (obs_ov_val.size() != 2 || obs_ov_val[0] !== 32'd6 || obs_ov_val[1] !== 32'd0) begin n_fail++; $display("FAIL wd_out_0: got %0d values expected 6 then 0", obs_ov_val.size()); end
        n_checks++; if (obs_rdy_cyc.size() != 2 || obs_rdy_cyc[1] != c1 + 3) begin n_fail++; $display("FAIL wd_zero_ready_cycle: got %0d expected %0d", obs_rdy_cyc.size() == 2 ? obs_rdy_cyc[1] : -1, c1 + 3); end
        n_checks++; if (err_sum() != 0) begin n_fail++; $display("FAIL wd_protocol: got %0d errors expected 0", err_sum()); end
    endtask

    task automatic test_random();
        bit ok;
        bit all_ok;
        int total;
        do_reset();
        clear_logs();
        total = 0;
        all_ok = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                cli_valid[i] = 1'($urandom_range(0, 1));
                cli_delay[i] = $urandom_range(0, 7);
                remaining[i] = int'($urandom_range(0, 2));
            end
            if (cli_valid == '0) cli_valid[$urandom_range(0, N - 1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (cli_valid[i]) total += 1 + remaining[i];
                else remaining[i] = 0;
            end
            step();
            wait_idle(ok);
            if (!ok) all_ok = 1'b0;
        end
        n_checks++; if (!all_ok) begin n_fail++; $display("FAIL rand_timeout: got busy expected idle"); end
        n_checks++; if (obs_rdy_client.size() != total) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs_rdy_client.size(), total); end
        n_checks++; if (exp_client.size() != obs_rdy_client.size()) begin n_fail++; $display("FAIL rand_model_count: got %0d expected %0d", obs_rdy_client.size(), exp_client.size()); end
        for (int i = 0; i < exp_client.size() && i < obs_rdy_client.size(); i++) begin
            n_checks++; if (obs_rdy_client[i] != exp_client[i]) begin n_fail++; $display("FAIL rand_order[%0d]: got %0d expected %0d", i, obs_rdy_client[i], exp_client[i]); end
            n_checks++; if (obs_ov_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL rand_out_0[%0d]: got %0d expected %0d", i, obs_ov_val[i], exp_val[i]); end
        end
        n_checks++; if (err_sum() != 0) begin n_fail++; $display("FAIL rand_protocol: got %0d errors expected 0", err_sum()); end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_spurious();
        test_reset_mid();
        test_withdraw_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
